uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_sched.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that feeds bytes from NUM_REQ requesters into one UART transmitter.
// Latency: grant one cycle after req_valid is seen, req_ready the cycle after, tx_enable the cycle after that.
// Backpressure: a granted requester holds the transmitter until its last byte; tx_busy paces every byte.
module uart_tx_sched #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_enable,
  input  logic                   tx_busy,
  output logic                   grant_valid,
  output logic [2:0]             grant_id,
  output logic                   err_timeout,
  output logic [15:0]            byte_count
);

  localparam int CW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_MAX = CW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_START, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [2:0]    rr_ptr_q, rr_ptr_d;
  logic          grant_valid_q, grant_valid_d;
  logic [2:0]    grant_id_q, grant_id_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_timeout_q, err_timeout_d;
  logic [15:0]   byte_count_q, byte_count_d;

  logic [2*NUM_REQ-1:0] rot;
  logic                 arb_found;
  logic [3:0]           arb_off;
  logic [3:0]           arb_sum;
  logic [2:0]           arb_idx;
  logic                 sel_valid;
  logic [7:0]           sel_data;
  logic                 sel_last;
  logic [2:0]           nxt_ptr;

  // Rotate the request vector so index rr_ptr sits at bit 0, then take the lowest set bit.
  always_comb begin
    rot       = {req_valid, req_valid} >> rr_ptr_q;
    arb_found = 1'b0;
    arb_off   = 4'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!arb_found && rot[i]) begin
        arb_found = 1'b1;
        arb_off   = 4'(i);
      end
    end
    arb_sum = {1'b0, rr_ptr_q} + arb_off;
    if (arb_sum >= 4'(NUM_REQ)) begin
      arb_sum = arb_sum - 4'(NUM_REQ);
    end
    arb_idx = arb_sum[2:0];
  end

  // Select the granted requester's byte, last flag and valid; compute the post-release pointer.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = 8'h00;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == 3'(i)) begin
        sel_valid = req_valid[i];
        sel_data  = req_data[8*i +: 8];
        sel_last  = req_last[i];
      end
    end
    nxt_ptr = (grant_id_q == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id_q + 3'd1;
  end

  // Next-state and output logic of the scheduling FSM.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    tx_data_d     = tx_data_q;
    last_d        = last_q;
    cnt_d         = '0;
    err_timeout_d = 1'b0;
    byte_count_d  = byte_count_q;
    req_ready     = '0;
    tx_enable     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          grant_valid_d = 1'b1;
          grant_id_d    = arb_idx;
          state_d       = S_LOAD;
        end
      end
      S_LOAD: begin
        // Grant is held while the owner has no byte: packets never interleave.
        if (sel_valid) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (grant_id_q == 3'(i));
          end
          tx_data_d = sel_data;
          last_d    = sel_last;
          state_d   = S_START;
        end
      end
      S_START: begin
        tx_enable = 1'b1;
        if (tx_busy) begin
          state_d = S_WAIT;
          if (byte_count_q != 16'hFFFF) begin
            byte_count_d = byte_count_q + 16'd1;
          end
        end else if (cnt_q == TO_MAX) begin
          // Transmitter never responded: drop the byte and free the grant.
          err_timeout_d = 1'b1;
          grant_valid_d = 1'b0;
          rr_ptr_d      = nxt_ptr;
          state_d       = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (!tx_busy) begin
          if (last_q) begin
            grant_valid_d = 1'b0;
            rr_ptr_d      = nxt_ptr;
            state_d       = S_IDLE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= 3'd0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= 3'd0;
      tx_data_q     <= 8'h00;
      last_q        <= 1'b0;
      cnt_q         <= '0;
      err_timeout_q <= 1'b0;
      byte_count_q  <= 16'd0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      tx_data_q     <= tx_data_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      err_timeout_q <= err_timeout_d;
      byte_count_q  <= byte_count_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign err_timeout = err_timeout_q;
  assign byte_count  = byte_count_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: directed packets, a tx_busy responder model and a decoupled monitor.
// Each accepted byte is compared against the queued (requester, data) expectation.
// Responder holds tx_busy for three cycles per byte unless disabled.
module tb_uart_tx_sched;
  localparam int NR = 4;

  typedef struct packed {
    logic [2:0] id;
    logic [7:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [8*NR-1:0] req_data = '0;
  logic [NR-1:0]   req_last = '0;
  logic [NR-1:0]   req_ready;
  logic [7:0]      tx_data;
  logic            tx_enable;
  logic            tx_busy = 1'b0;
  logic            grant_valid;
  logic [2:0]      grant_id;
  logic            err_timeout;
  logic [15:0]     byte_count;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  logic [8:0] pkt [NR][8];
  int         cnt [NR];
  int         pos [NR];
  bit         model_en = 1'b1;

  uart_tx_sched #(.NUM_REQ(NR), .BUSY_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_data(tx_data), .tx_enable(tx_enable), .tx_busy(tx_busy),
    .grant_valid(grant_valid), .grant_id(grant_id),
    .err_timeout(err_timeout), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic add_byte(input int r, input logic [7:0] d, input logic l);
    pkt[r][cnt[r]] = {l, d};
    cnt[r]++;
  endtask

  task automatic expect_byte(input int r, input logic [7:0] d);
    exp_t e;
    e.id   = 3'(r);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NR; i++) begin
      cnt[i] = 0;
      pos[i] = 0;
    end
    exp_q.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"},   32'(req_ready),   32'd0);
    chk({tag, "_tx_enable"},   32'(tx_enable),   32'd0);
    chk({tag, "_tx_data"},     32'(tx_data),     32'd0);
    chk({tag, "_grant_valid"}, 32'(grant_valid), 32'd0);
    chk({tag, "_grant_id"},    32'(grant_id),    32'd0);
    chk({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
    chk({tag, "_byte_count"},  32'(byte_count),  32'd0);
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    #1;
    clear_reqs();
    chk_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !grant_valid;
      for (int i = 0; i < NR; i++) if (pos[i] < cnt[i]) done = 1'b0;
    end
    if (!done) begin
      errors++;
      $display("FAIL %s drain_timeout pending=%0d required=0", name, exp_q.size());
    end
  endtask

  // Requester driver: retire a byte one cycle after its strobe, then present the next.
  initial begin
    logic [NR-1:0] rdy_prev;
    rdy_prev = '0;
    for (int i = 0; i < NR; i++) begin
      cnt[i] = 0;
      pos[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) if (rdy_prev[i] && pos[i] < cnt[i]) pos[i]++;
      rdy_prev = rst_n ? req_ready : '0;
      for (int i = 0; i < NR; i++) begin
        req_valid[i] = (pos[i] < cnt[i]);
        req_data[8*i +: 8] = (pos[i] < cnt[i]) ? pkt[i][pos[i]][7:0] : 8'h00;
        req_last[i] = (pos[i] < cnt[i]) ? pkt[i][pos[i]][8] : 1'b0;
      end
    end
  end

  // Transmitter model: raise busy on tx_enable, hold it three cycles.
  initial begin
    int bcnt;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tx_busy = 1'b0;
        bcnt = 0;
      end else if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) tx_busy = 1'b0;
      end else if (model_en && tx_enable) begin
        tx_busy = 1'b1;
        bcnt = 3;
      end
    end
  end

  // Monitor: every req_ready pops one expectation; the next tx_enable rise checks the byte.
  initial begin
    exp_t       e;
    logic [7:0] pend;
    bit         pend_vld;
    logic       en_prev;
    pend_vld = 1'b0;
    en_prev  = 1'b0;
    pend     = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend_vld = 1'b0;
        en_prev  = 1'b0;
      end else begin
        if (req_ready != '0) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready actual=%0h required=0", req_ready);
          end else begin
            e = exp_q.pop_front();
            chk("ready_onehot", 32'(req_ready), 32'(NR'(1) << e.id));
            chk("grant_id", 32'(grant_id), 32'(e.id));
            chk("grant_valid_at_ready", 32'(grant_valid), 32'd1);
            pend = e.data;
            pend_vld = 1'b1;
          end
        end
        if (tx_enable && !en_prev && pend_vld) begin
          chk("tx_data", 32'(tx_data), 32'(pend));
          pend_vld = 1'b0;
        end
        en_prev = tx_enable;
      end
    end
  end

  initial begin
    int  k;
    bit  hit;

    // Single byte from requester 0.
    do_reset();
    add_byte(0, 8'h55, 1'b1);
    expect_byte(0, 8'h55);
    wait_idle("single", 200);
    chk("single_byte_count", 32'(byte_count), 32'd1);
    chk("single_grant_released", 32'(grant_valid), 32'd0);

    // Round robin: all four requesters hold two single-byte packets.
    do_reset();
    for (int r = 0; r < NR; r++) begin
      add_byte(r, 8'h10 + 8'(r), 1'b1);
      add_byte(r, 8'h20 + 8'(r), 1'b1);
    end
    for (int r = 0; r < NR; r++) expect_byte(r, 8'h10 + 8'(r));
    for (int r = 0; r < NR; r++) expect_byte(r, 8'h20 + 8'(r));
    wait_idle("rr", 400);
    chk("rr_byte_count", 32'(byte_count), 32'd8);

    // Packet lock: requester 2 owns the grant, requester 0 shows up mid-packet.
    do_reset();
    add_byte(2, 8'h2a, 1'b0);
    add_byte(2, 8'h2b, 1'b0);
    add_byte(2, 8'h2c, 1'b1);
    expect_byte(2, 8'h2a);
    expect_byte(2, 8'h2b);
    expect_byte(2, 8'h2c);
    expect_byte(0, 8'h0a);
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      hit = grant_valid && (grant_id == 3'd2);
    end
    chk("lock_grant2", 32'(hit), 32'd1);
    add_byte(0, 8'h0a, 1'b1);
    wait_idle("lock", 400);
    chk("lock_byte_count", 32'(byte_count), 32'd4);

    // Timeout: transmitter never raises busy.
    model_en = 1'b0;
    do_reset();
    add_byte(1, 8'h77, 1'b1);
    expect_byte(1, 8'h77);
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      hit = tx_enable;
    end
    chk("to_enable_seen", 32'(hit), 32'd1);
    k = 0;
    hit = 1'b0;
    while (k < 40 && !hit) begin
      @(negedge clk);
      k++;
      hit = err_timeout;
    end
    chk("to_latency", 32'(k), 32'd16);
    chk("to_enable_dropped", 32'(tx_enable), 32'd0);
    chk("to_byte_count", 32'(byte_count), 32'd0);
    chk("to_grant_released", 32'(grant_valid), 32'd0);
    @(negedge clk);
    chk("to_pulse_width", 32'(err_timeout), 32'd0);
    model_en = 1'b1;
    add_byte(1, 8'h78, 1'b1);
    add_byte(2, 8'h79, 1'b1);
    expect_byte(2, 8'h79);
    expect_byte(1, 8'h78);
    wait_idle("to_after", 300);
    chk("to_after_byte_count", 32'(byte_count), 32'd2);

    // Reset while requester 3 is mid-packet in the wait state.
    do_reset();
    add_byte(0, 8'h40, 1'b1);
    add_byte(1, 8'h41, 1'b1);
    add_byte(2, 8'h42, 1'b1);
    add_byte(3, 8'h3a, 1'b0);
    add_byte(3, 8'h3b, 1'b1);
    for (int r = 0; r < 3; r++) expect_byte(r, 8'h40 + 8'(r));
    expect_byte(3, 8'h3a);
    hit = 1'b0;
    for (int c = 0; c < 300 && !hit; c++) begin
      @(negedge clk);
      hit = (byte_count == 16'd4) && (grant_id == 3'd3) && tx_busy;
    end
    chk("mid_wait_reached", 32'(hit), 32'd1);
    chk("mid_wait_all_accepted", 32'(exp_q.size()), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    clear_reqs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    add_byte(0, 8'h50, 1'b1);
    add_byte(3, 8'h53, 1'b1);
    expect_byte(0, 8'h50);
    expect_byte(3, 8'h53);
    wait_idle("post_reset", 300);
    chk("post_reset_byte_count", 32'(byte_count), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
